// File: rtl/ds1302_access_sched.sv
// ds1302_access_sched: shares the DS1302 engine among set, get and refresh requests.
// Define DS1302_SCHED_READBACK_EN to follow every set with a verifying read.
module ds1302_access_sched #(
    parameter int POLL_CYCLES  = 10_000_000,
    parameter int OP_CYCLES    = 32_500,
    parameter int GUARD_CYCLES = 2_500
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        set_req,
    input  logic [63:0] set_time,
    input  logic        get_req,
    input  logic        poll_en,
    input  logic [63:0] bcd_time_get,
    output logic        set_trig,
    output logic        get_trig,
    output logic [63:0] set_data,
    output logic [63:0] time_out,
    output logic        time_valid,
    output logic        set_done,
    output logic        busy
);
    localparam int W  = OP_CYCLES + GUARD_CYCLES;
    localparam int WW = $clog2(W);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam logic [WW-1:0] W_LAST = WW'(W - 1);
    localparam logic [WW-1:0] W_DONE = WW'(W - 2);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {STARTUP, IDLE, ISSUE_SET, WAIT_SET, ISSUE_GET, WAIT_GET, CAPTURE} state_t;

    state_t state;
    logic [WW-1:0] wcnt;
    logic [PW-1:0] pcnt;
    logic set_pend, get_pend;
    logic [63:0] shadow;
    logic wrap, timed, expire, go_set, go_get, readback;

    assign wrap   = poll_en && pcnt == P_LAST;
    assign timed  = state == STARTUP || state == WAIT_SET || state == WAIT_GET;
    assign expire = timed && wcnt == W_LAST;
    assign go_set = state == IDLE && set_pend;
    assign go_get = state == IDLE && !set_pend && get_pend;
    assign busy   = state != IDLE;
`ifdef DS1302_SCHED_READBACK_EN
    assign readback = state == WAIT_SET && expire;
`else
    assign readback = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= STARTUP;
            wcnt       <= '0;
            pcnt       <= '0;
            set_pend   <= 1'b0;
            get_pend   <= 1'b0;
            shadow     <= '0;
            set_trig   <= 1'b0;
            get_trig   <= 1'b0;
            set_data   <= '0;
            time_out   <= '0;
            time_valid <= 1'b0;
            set_done   <= 1'b0;
        end else begin
            set_trig   <= go_set;
            get_trig   <= go_get;
            time_valid <= state == WAIT_GET && expire;
            set_done   <= state == WAIT_SET && wcnt == W_DONE;
            wcnt       <= timed && !expire ? wcnt + 1'b1 : '0;
            pcnt       <= wrap || !poll_en ? '0 : pcnt + 1'b1;
            set_pend   <= set_req || (set_pend && !go_set);
            get_pend   <= get_req || wrap || readback || (get_pend && !go_get);
            if (set_req)
                shadow <= set_time;
            if (go_set)
                set_data <= shadow;
            if (state == WAIT_GET && expire)
                time_out <= bcd_time_get;
            // a new set_req only touches shadow/flag, so the running operation is undisturbed
            case (state)
                STARTUP:   state <= expire ? IDLE : STARTUP;
                IDLE:      state <= go_set ? ISSUE_SET : go_get ? ISSUE_GET : IDLE;
                ISSUE_SET: state <= WAIT_SET;
                WAIT_SET:  state <= expire ? IDLE : WAIT_SET;
                ISSUE_GET: state <= WAIT_GET;
                WAIT_GET:  state <= expire ? CAPTURE : WAIT_GET;
                CAPTURE:   state <= IDLE;
                default:   state <= STARTUP;
            endcase
        end
    end
endmodule

// File: tb/tb_ds1302_access_sched.sv
// tb_ds1302_access_sched: directed checks of the DS1302 access scheduler (W = 24).
module tb_ds1302_access_sched;
    localparam int W = 24;
`ifdef DS1302_SCHED_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif
    localparam logic [63:0] T0 = 64'h0078060815012900;
    localparam logic [63:0] T1 = 64'h0078060815010030;

    logic sclk = 1'b0, rst = 1'b1, set_req = 1'b0, get_req = 1'b0, poll_en = 1'b0;
    logic [63:0] set_time = '0, bcd_time_get = '0;
    logic set_trig, get_trig, time_valid, set_done, busy;
    logic [63:0] set_data, time_out;
    int passed = 0, total = 0;
    int n_set = 0, n_get = 0, cyc = 0, last_trig = -1000, min_gap = 1000000;

    ds1302_access_sched #(.POLL_CYCLES(200), .OP_CYCLES(20), .GUARD_CYCLES(4)) dut (
        .sclk(sclk), .rst(rst), .set_req(set_req), .set_time(set_time), .get_req(get_req),
        .poll_en(poll_en), .bcd_time_get(bcd_time_get), .set_trig(set_trig), .get_trig(get_trig),
        .set_data(set_data), .time_out(time_out), .time_valid(time_valid), .set_done(set_done),
        .busy(busy)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        cyc++;
        if (set_trig) n_set++;
        if (get_trig) n_get++;
        if (set_trig || get_trig) begin
            if (cyc - last_trig < min_gap) min_gap = cyc - last_trig;
            last_trig = cyc;
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0, n = 0;
        while (quiet < 3 && n < 500) begin
            tick();
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        total++;
        if (quiet < 3) $display("FAIL %s idle timeout: busy=%0b after %0d cycles, required idle", name, busy, n);
        else passed++;
    endtask

    task automatic test_reset();
        int n = 0, trig0;
        rst = 1'b1;
        repeat (3) tick();
        total += 4;
        if (busy !== 1'b1) $display("FAIL reset busy: got %0b want 1", busy); else passed++;
        if ({set_trig, get_trig, time_valid, set_done} !== 4'b0) $display("FAIL reset pulses: got %b want 0000", {set_trig, get_trig, time_valid, set_done}); else passed++;
        if (time_out !== 64'd0) $display("FAIL reset time_out: got %h want 0", time_out); else passed++;
        if (set_data !== 64'd0) $display("FAIL reset set_data: got %h want 0", set_data); else passed++;
        trig0 = n_set + n_get;
        rst = 1'b0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        repeat (2) tick();
        total += 2;
        if (n !== W) $display("FAIL startup busy length: got %0d want %0d", n, W); else passed++;
        if (n_set + n_get - trig0 !== 0) $display("FAIL startup triggers: got %0d want 0", n_set + n_get - trig0); else passed++;
    endtask

    task automatic test_get();
        int n = 1;
        bcd_time_get = T0;
        get_req = 1'b1;
        tick();
        get_req = 1'b0;
        total += 6;
        if (get_trig !== 1'b0) $display("FAIL get early trig: got %0b want 0", get_trig); else passed++;
        tick();
        if (get_trig !== 1'b1) $display("FAIL get latency: got %0b want 1", get_trig); else passed++;
        tick();
        if (get_trig !== 1'b0) $display("FAIL get trig width: got %0b want 0", get_trig); else passed++;
        while (!time_valid && n < 100) begin
            tick();
            n++;
        end
        if (n !== W + 1) $display("FAIL get valid delay: got %0d want %0d", n, W + 1); else passed++;
        if (time_out !== T0) $display("FAIL get time_out: got %h want %h", time_out, T0); else passed++;
        tick();
        if ({time_valid, busy} !== 2'b00) $display("FAIL get end: valid,busy=%b want 00", {time_valid, busy}); else passed++;
    endtask

    task automatic test_set_overwrite();
        int n = 0;
        logic bad = 1'b0;
        set_time = T0;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        total += 6;
        if (set_trig !== 1'b1 || set_data !== T0) $display("FAIL set first trig: trig=%0b data=%h want 1 %h", set_trig, set_data, T0); else passed++;
        while (n < 100) begin
            tick();
            n++;
            if (set_data !== T0 || set_trig) bad = 1'b1;
            if (set_done) break;
            set_req = n == 5;
            if (n == 5) set_time = T1;
        end
        set_req = 1'b0;
        if (bad !== 1'b0) $display("FAIL set data stable: disturbed=%0b want 0", bad); else passed++;
        if (n !== W) $display("FAIL set done delay: got %0d want %0d", n, W); else passed++;
        tick();
        if (set_trig !== 1'b0) $display("FAIL set early second trig: got %0b want 0", set_trig); else passed++;
        tick();
        if (set_trig !== 1'b1) $display("FAIL set second trig: got %0b want 1", set_trig); else passed++;
        if (set_data !== T1) $display("FAIL set second data: got %h want %h", set_data, T1); else passed++;
        wait_idle("set_overwrite");
    endtask

    task automatic test_readback();
        int n = 0;
        set_time = T1;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        while (!set_done && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        total += 2;
        if (n >= 100) $display("FAIL readback set_done timeout: waited %0d want <100", n); else passed++;
        if (get_trig !== RB) $display("FAIL readback get_trig: got %0b want %0b", get_trig, RB); else passed++;
        wait_idle("readback");
    endtask

    task automatic test_simultaneous();
        int s0, g0, n = 0;
        poll_en = 1'b1;
        repeat (199) tick();
        s0 = n_set;
        g0 = n_get;
        set_time = T0;
        set_req = 1'b1;
        get_req = 1'b1;
        tick();
        set_req = 1'b0;
        get_req = 1'b0;
        poll_en = 1'b0;
        tick();
        total += 5;
        if ({set_trig, get_trig} !== 2'b10) $display("FAIL simul first trig: set,get=%b want 10", {set_trig, get_trig}); else passed++;
        while (!get_trig && n < 100) begin
            tick();
            n++;
        end
        if (n !== W + 2) $display("FAIL simul get spacing: got %0d want %0d", n, W + 2); else passed++;
        repeat (80) tick();
        if (n_set - s0 !== 1) $display("FAIL simul set count: got %0d want 1", n_set - s0); else passed++;
        if (n_get - g0 !== 1) $display("FAIL simul get count: got %0d want 1", n_get - g0); else passed++;
        if (min_gap < W + 1) $display("FAIL simul min spacing: got %0d want >=%0d", min_gap, W + 1); else passed++;
    endtask

    task automatic test_poll();
        int cnt = 0, prev = 0;
        logic bad = 1'b0;
        poll_en = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (set_trig) bad = 1'b1;
            if (get_trig) begin
                if (prev > 0 && i - prev != 200) bad = 1'b1;
                if (prev == 0 && i != 201) bad = 1'b1;
                prev = i;
                cnt++;
            end
        end
        poll_en = 1'b0;
        wait_idle("poll");
        total += 3;
        if (cnt !== 4) $display("FAIL poll count: got %0d want 4", cnt); else passed++;
        if (bad !== 1'b0) $display("FAIL poll period: irregular=%0b want 0", bad); else passed++;
        if (min_gap < W + 1) $display("FAIL poll min spacing: got %0d want >=%0d", min_gap, W + 1); else passed++;
    endtask

    task automatic test_reset_mid();
        int nb;
        logic bad = 1'b0;
        get_req = 1'b1;
        tick();
        get_req = 1'b0;
        tick();
        total += 5;
        if (get_trig !== 1'b1) $display("FAIL mid get trig: got %0b want 1", get_trig); else passed++;
        repeat (11) tick();
        rst = 1'b1;
        set_req = 1'b1;
        set_time = T1;
        tick();
        set_req = 1'b0;
        tick();
        rst = 1'b0;
        if (time_out !== 64'd0) $display("FAIL mid time_out: got %h want 0", time_out); else passed++;
        nb = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (set_trig || get_trig || time_valid) bad = 1'b1;
            if (busy) nb++;
        end
        if (bad !== 1'b0) $display("FAIL mid activity after reset: seen=%0b want 0", bad); else passed++;
        if (nb !== W) $display("FAIL mid startup length: got %0d want %0d", nb, W); else passed++;
        if (set_data !== 64'd0) $display("FAIL mid set_data: got %h want 0", set_data); else passed++;
    endtask

    initial begin
        test_reset();
        wait_idle("reset");
        test_get();
        test_set_overwrite();
        test_readback();
        test_simultaneous();
        test_poll();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
